// File: rtl/tff_counter_seq.sv
// tff_counter_seq
// ---------------------------------------------------------------------------
// Sequencer for a bank of WIDTH T-type flip-flops used as a loadable up/down
// counter. The controller FSM computes a per-bit toggle vector t each cycle,
// and the bank updates as q <= q ^ t. There is no direct data path into q:
// loads, steps and holds are all expressed as toggle patterns.
//
// Optional build feature (macro TFF_SEQ_AUTORELOAD_EN):
//   defined   - leaving DONE reloads q from load_val and returns to RUN,
//               so done pulses once per terminal count indefinitely.
//   undefined - leaving DONE returns to IDLE with q holding the limit.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset (0 = reset)
//   start    in   begin or resume counting (IDLE/PAUSE)
//   stop     in   pause counting (RUN only)
//   up_dn    in   1 = count up, 0 = count down; sampled every cycle
//   load     in   load load_val (IDLE/PAUSE only)
//   load_val in   [WIDTH-1:0] load / reload value
//   limit    in   [WIDTH-1:0] terminal count, compared live every RUN cycle
//   q        out  [WIDTH-1:0] counter state
//   qb       out  [WIDTH-1:0] always ~q
//   busy     out  high in RUN or PAUSE
//   done     out  high exactly while the state is DONE
//   state    out  [1:0] FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11
//
// Command semantics: start/stop/load are level-sampled commands with no
// handshake. A command present at a rising edge takes effect on that edge
// and is visible on the registered outputs after it (one cycle of latency).
// Commands that are not meaningful in the current state are ignored.
// ---------------------------------------------------------------------------
module tff_counter_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  logic [1:0]       state_q;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] t_dn;
  logic [WIDTH-1:0] t_load;

  // Step toggle vectors: bit i toggles when all lower bits are 1 (up)
  // or all lower bits are 0 (down). The carries are accumulated in local
  // variables so the vectors are never read back inside this block.
  always_comb begin
    logic up_c;
    logic dn_c;
    t_up = '0;
    t_dn = '0;
    up_c = 1'b1;
    dn_c = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t_up[i] = up_c;
      t_dn[i] = dn_c;
      up_c    = up_c & q_reg[i];
      dn_c    = dn_c & ~q_reg[i];
    end
  end

  // Toggling exactly the bits that differ turns q into load_val.
  assign t_load = q_reg ^ load_val;

  // Controller: next state and toggle vector.
  always_comb begin
    state_next = state_q;
    t          = '0;
    case (state_q)
      ST_IDLE: begin
        if (load)  t          = t_load;
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        // Priority: stop > terminal count > step. load is ignored here.
        if (stop) begin
          state_next = ST_PAUSE;
        end else if (q_reg == limit) begin
          state_next = ST_DONE;
        end else begin
          t = up_dn ? t_up : t_dn;
        end
      end
      ST_PAUSE: begin
        // Resuming never steps on the resume edge; stop is ignored.
        if (load)  t          = t_load;
        if (start) state_next = ST_RUN;
      end
      ST_DONE: begin
`ifdef TFF_SEQ_AUTORELOAD_EN
        t          = t_load;
        state_next = ST_RUN;
`else
        state_next = ST_IDLE;
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      q_reg   <= '0;
    end else begin
      state_q <= state_next;
      q_reg   <= q_reg ^ t;
    end
  end

  // All outputs decode registered state only.
  assign q     = q_reg;
  assign qb    = ~q_reg;
  assign state = state_q;
  assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign done  = (state_q == ST_DONE);

endmodule
